// File: rtl/reservation_station.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reservation_station : ALU-path issue buffer with broadcast wakeup/bypass
// Revision 1.0
// ---------------------------------------------------------------------------
module reservation_station #(
   parameter int RS_SIZE = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        issue_valid,
   input  logic [5:0]  issue_opcode,
   input  logic [31:0] issue_val1,
   input  logic [31:0] issue_val2,
   input  logic        issue_dep1,
   input  logic        issue_dep2,
   input  logic [5:0]  issue_tag1,
   input  logic [5:0]  issue_tag2,
   input  logic [31:0] issue_imm,
   input  logic [31:0] issue_pc,
   input  logic [5:0]  issue_rob_index,
   input  logic        alu_valid,
   input  logic [31:0] alu_res,
   input  logic [5:0]  alu_rob_index,
   input  logic        lsb_valid,
   input  logic [31:0] lsb_res,
   input  logic [5:0]  lsb_rob_index,
   output logic        rs_full,
   output logic [5:0]  opcode,
   output logic [31:0] val1,
   output logic [31:0] val2,
   output logic [31:0] imm,
   output logic [31:0] pc,
   output logic [5:0]  rob_index
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [RS_SIZE-1:0] dep1_q, dep1_d;
   logic [RS_SIZE-1:0] dep2_q, dep2_d;
   logic [5:0]         op_q   [RS_SIZE];
   logic [5:0]         op_d   [RS_SIZE];
   logic [31:0]        v1_q   [RS_SIZE];
   logic [31:0]        v1_d   [RS_SIZE];
   logic [31:0]        v2_q   [RS_SIZE];
   logic [31:0]        v2_d   [RS_SIZE];
   logic [5:0]         t1_q   [RS_SIZE];
   logic [5:0]         t1_d   [RS_SIZE];
   logic [5:0]         t2_q   [RS_SIZE];
   logic [5:0]         t2_d   [RS_SIZE];
   logic [31:0]        imm_q  [RS_SIZE];
   logic [31:0]        imm_d  [RS_SIZE];
   logic [31:0]        pc_q   [RS_SIZE];
   logic [31:0]        pc_d   [RS_SIZE];
   logic [5:0]         rob_q  [RS_SIZE];
   logic [5:0]         rob_d  [RS_SIZE];

   logic [5:0]  out_op_q, out_op_d;
   logic [31:0] out_v1_q, out_v1_d;
   logic [31:0] out_v2_q, out_v2_d;
   logic [31:0] out_imm_q, out_imm_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [5:0]  out_rob_q, out_rob_d;

   logic             free_found, rdy_found;
   logic [IDX_W-1:0] free_idx, rdy_idx;
   logic [32:0]      w_iss1, w_iss2, w_wk1, w_wk2;

   // Returns {dep, value} after snooping both buses; ALU takes precedence.
   function automatic logic [32:0] snoop(
      input logic        dep,
      input logic [5:0]  tag,
      input logic [31:0] val,
      input logic        a_v,
      input logic [5:0]  a_tag,
      input logic [31:0] a_res,
      input logic        l_v,
      input logic [5:0]  l_tag,
      input logic [31:0] l_res
   );
      logic [32:0] r;
      r = {dep, val};
      if (dep && a_v && (a_tag == tag))
         r = {1'b0, a_res};
      else if (dep && l_v && (l_tag == tag))
         r = {1'b0, l_res};
      return r;
   endfunction

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      rdy_found  = 1'b0;
      rdy_idx    = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!free_found && !busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (!rdy_found && busy_q[i] && !dep1_q[i] && !dep2_q[i]) begin
            rdy_found = 1'b1;
            rdy_idx   = IDX_W'(i);
         end
      end
   end

   assign rs_full = &busy_q;

   assign w_iss1 = snoop(issue_dep1, issue_tag1, issue_val1, alu_valid, alu_rob_index,
                         alu_res, lsb_valid, lsb_rob_index, lsb_res);
   assign w_iss2 = snoop(issue_dep2, issue_tag2, issue_val2, alu_valid, alu_rob_index,
                         alu_res, lsb_valid, lsb_rob_index, lsb_res);

   always_comb begin
      busy_d    = busy_q;
      dep1_d    = dep1_q;
      dep2_d    = dep2_q;
      op_d      = op_q;
      v1_d      = v1_q;
      v2_d      = v2_q;
      t1_d      = t1_q;
      t2_d      = t2_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      rob_d     = rob_q;
      out_op_d  = out_op_q;
      out_v1_d  = out_v1_q;
      out_v2_d  = out_v2_q;
      out_imm_d = out_imm_q;
      out_pc_d  = out_pc_q;
      out_rob_d = out_rob_q;
      w_wk1     = '0;
      w_wk2     = '0;

      if (clear) begin
         busy_d   = '0;
         out_op_d = '0;
      end else begin
         if (rdy_found) begin
            out_op_d          = op_q[rdy_idx];
            out_v1_d          = v1_q[rdy_idx];
            out_v2_d          = v2_q[rdy_idx];
            out_imm_d         = imm_q[rdy_idx];
            out_pc_d          = pc_q[rdy_idx];
            out_rob_d         = rob_q[rdy_idx];
            busy_d[rdy_idx]   = 1'b0;
         end else begin
            out_op_d = '0;
         end

         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
               w_wk1 = snoop(dep1_q[i], t1_q[i], v1_q[i], alu_valid, alu_rob_index,
                             alu_res, lsb_valid, lsb_rob_index, lsb_res);
               w_wk2 = snoop(dep2_q[i], t2_q[i], v2_q[i], alu_valid, alu_rob_index,
                             alu_res, lsb_valid, lsb_rob_index, lsb_res);
               {dep1_d[i], v1_d[i]} = w_wk1;
               {dep2_d[i], v2_d[i]} = w_wk2;
            end
         end

         // The free slot is non-busy pre-edge, so it never collides with wakeup or dispatch.
         if (issue_valid && !rs_full) begin
            busy_d[free_idx]              = 1'b1;
            op_d[free_idx]                = issue_opcode;
            {dep1_d[free_idx], v1_d[free_idx]} = w_iss1;
            {dep2_d[free_idx], v2_d[free_idx]} = w_iss2;
            t1_d[free_idx]                = issue_tag1;
            t2_d[free_idx]                = issue_tag2;
            imm_d[free_idx]               = issue_imm;
            pc_d[free_idx]                = issue_pc;
            rob_d[free_idx]               = issue_rob_index;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q    <= '0;
         dep1_q    <= '0;
         dep2_q    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]  <= '0;
            v1_q[i]  <= '0;
            v2_q[i]  <= '0;
            t1_q[i]  <= '0;
            t2_q[i]  <= '0;
            imm_q[i] <= '0;
            pc_q[i]  <= '0;
            rob_q[i] <= '0;
         end
         out_op_q  <= '0;
         out_v1_q  <= '0;
         out_v2_q  <= '0;
         out_imm_q <= '0;
         out_pc_q  <= '0;
         out_rob_q <= '0;
      end else if (rdy_in) begin
         busy_q    <= busy_d;
         dep1_q    <= dep1_d;
         dep2_q    <= dep2_d;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]  <= op_d[i];
            v1_q[i]  <= v1_d[i];
            v2_q[i]  <= v2_d[i];
            t1_q[i]  <= t1_d[i];
            t2_q[i]  <= t2_d[i];
            imm_q[i] <= imm_d[i];
            pc_q[i]  <= pc_d[i];
            rob_q[i] <= rob_d[i];
         end
         out_op_q  <= out_op_d;
         out_v1_q  <= out_v1_d;
         out_v2_q  <= out_v2_d;
         out_imm_q <= out_imm_d;
         out_pc_q  <= out_pc_d;
         out_rob_q <= out_rob_d;
      end
   end

   assign opcode    = out_op_q;
   assign val1      = out_v1_q;
   assign val2      = out_v2_q;
   assign imm       = out_imm_q;
   assign pc        = out_pc_q;
   assign rob_index = out_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reservation_station : directed + random checks against a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_reservation_station;

   localparam int RS = 16;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear, issue_valid;
   logic [5:0]  issue_opcode, issue_tag1, issue_tag2, issue_rob_index;
   logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
   logic        issue_dep1, issue_dep2;
   logic        alu_valid, lsb_valid;
   logic [31:0] alu_res, lsb_res;
   logic [5:0]  alu_rob_index, lsb_rob_index;
   logic        rs_full;
   logic [5:0]  opcode, rob_index;
   logic [31:0] val1, val2, imm, pc;

   int n_total = 0;
   int n_bad   = 0;

   reservation_station #(.RS_SIZE(RS)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .issue_valid(issue_valid), .issue_opcode(issue_opcode),
      .issue_val1(issue_val1), .issue_val2(issue_val2),
      .issue_dep1(issue_dep1), .issue_dep2(issue_dep2),
      .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_index(issue_rob_index),
      .alu_valid(alu_valid), .alu_res(alu_res), .alu_rob_index(alu_rob_index),
      .lsb_valid(lsb_valid), .lsb_res(lsb_res), .lsb_rob_index(lsb_rob_index),
      .rs_full(rs_full), .opcode(opcode), .val1(val1), .val2(val2),
      .imm(imm), .pc(pc), .rob_index(rob_index)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit        busy;
      bit [5:0]  op;
      bit [31:0] v1, v2;
      bit        d1, d2;
      bit [5:0]  t1, t2;
      bit [31:0] im, pcv;
      bit [5:0]  rob;
   } ent_t;

   ent_t      m [RS];
   bit [5:0]  e_op, e_rob;
   bit [31:0] e_v1, e_v2, e_imm, e_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit [32:0] wake(input bit d, input bit [5:0] t, input bit [31:0] v);
      if (d && alu_valid && alu_rob_index == t) return {1'b0, alu_res};
      if (d && lsb_valid && lsb_rob_index == t) return {1'b0, lsb_res};
      return {d, v};
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      e_op = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
   endtask

   // Applies one rising edge's worth of behaviour using the inputs currently driven.
   task automatic model_edge();
      ent_t old [RS];
      int   r, f;
      bit   full;
      if (!rdy_in) return;
      if (clear) begin
         for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
         e_op = 0;
         return;
      end
      old  = m;
      r    = -1;
      f    = -1;
      full = model_full();
      for (int i = 0; i < RS; i++) begin
         if (!old[i].busy && f < 0) f = i;
         if (old[i].busy && !old[i].d1 && !old[i].d2 && r < 0) r = i;
      end
      if (r >= 0) begin
         e_op = old[r].op; e_v1 = old[r].v1; e_v2 = old[r].v2;
         e_imm = old[r].im; e_pc = old[r].pcv; e_rob = old[r].rob;
         m[r].busy = 1'b0;
      end else begin
         e_op = 0;
      end
      for (int i = 0; i < RS; i++) begin
         if (old[i].busy) begin
            {m[i].d1, m[i].v1} = wake(old[i].d1, old[i].t1, old[i].v1);
            {m[i].d2, m[i].v2} = wake(old[i].d2, old[i].t2, old[i].v2);
         end
      end
      if (issue_valid && !full) begin
         m[f].busy = 1'b1;
         m[f].op   = issue_opcode;
         {m[f].d1, m[f].v1} = wake(issue_dep1, issue_tag1, issue_val1);
         {m[f].d2, m[f].v2} = wake(issue_dep2, issue_tag2, issue_val2);
         m[f].t1 = issue_tag1; m[f].t2 = issue_tag2;
         m[f].im = issue_imm;  m[f].pcv = issue_pc; m[f].rob = issue_rob_index;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_in);
      #1;
      chk("opcode",    opcode,    e_op);
      chk("val1",      val1,      e_v1);
      chk("val2",      val2,      e_v2);
      chk("imm",       imm,       e_imm);
      chk("pc",        pc,        e_pc);
      chk("rob_index", rob_index, e_rob);
      chk("rs_full",   rs_full,   model_full());
   endtask

   task automatic issue(input bit [5:0] op, input bit [31:0] a, input bit [31:0] b,
                        input bit d1, input bit [5:0] t1, input bit d2, input bit [5:0] t2,
                        input bit [5:0] rob);
      issue_valid = 1'b1; issue_opcode = op;
      issue_val1 = a; issue_val2 = b;
      issue_dep1 = d1; issue_tag1 = t1; issue_dep2 = d2; issue_tag2 = t2;
      issue_imm = 32'h100 + rob; issue_pc = 32'h4000 + {rob, 2'b00};
      issue_rob_index = rob;
   endtask

   task automatic idle();
      issue_valid = 1'b0; clear = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1;
      idle();
      issue(6'd0, 0, 0, 0, 0, 0, 0, 0);
      issue_valid = 1'b0;
      alu_res = 0; alu_rob_index = 0; lsb_res = 0; lsb_rob_index = 0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_opcode", opcode, 0);
      chk("rst_val1", val1, 0);
      chk("rst_rob", rob_index, 0);
      chk("rst_full", rs_full, 0);
      rst_in = 1'b0;
      model_reset();

      // single ready ADD
      issue(6'd1, 5, 7, 0, 0, 0, 0, 6'd3);
      tick();
      idle();
      tick();
      chk("add_op", opcode, 1); chk("add_v1", val1, 5);
      chk("add_v2", val2, 7);   chk("add_rob", rob_index, 3);
      tick();
      chk("add_pulse", opcode, 0);

      // wakeup via ALU
      issue(6'd2, 0, 2, 1, 6'd9, 0, 0, 6'd5);
      tick();
      idle();
      tick();
      chk("wk_wait", opcode, 0);
      alu_valid = 1'b1; alu_rob_index = 6'd9; alu_res = 32'h10;
      tick();
      idle();
      chk("wk_capture", opcode, 0);
      tick();
      chk("wk_op", opcode, 2); chk("wk_v1", val1, 32'h10); chk("wk_v2", val2, 2);

      // same-cycle bypass from LSB
      issue(6'd3, 32'h11, 0, 0, 0, 1, 6'd4, 6'd6);
      lsb_valid = 1'b1; lsb_rob_index = 6'd4; lsb_res = 32'hFFFF_FFFF;
      tick();
      idle();
      tick();
      chk("byp_op", opcode, 3); chk("byp_v2", val2, 32'hFFFF_FFFF);

      // fill, overflow attempt, ordered drain
      for (int i = 0; i < RS; i++) begin
         issue(6'd4, 0, i, 1, 6'd1, 0, 0, 6'(i));
         tick();
      end
      chk("full_set", rs_full, 1);
      issue(6'd5, 1, 1, 0, 0, 0, 0, 6'd40);
      tick();
      idle();
      chk("full_hold", rs_full, 1);
      alu_valid = 1'b1; alu_rob_index = 6'd1; alu_res = 32'h77;
      tick();
      idle();
      for (int i = 0; i < RS; i++) begin
         tick();
         chk("drain_op", opcode, 4);
         chk("drain_rob", rob_index, i);
         if (i == 0) chk("full_drop", rs_full, 0);
      end
      tick();
      chk("drain_end", opcode, 0);

      // clear mid-operation
      for (int i = 0; i < 3; i++) begin
         issue(6'd6, 0, 0, 1, 6'd20, 0, 0, 6'(20 + i));
         tick();
      end
      issue(6'd7, 3, 4, 0, 0, 0, 0, 6'd30);
      tick();
      issue(6'd8, 1, 2, 0, 0, 0, 0, 6'd31);
      clear = 1'b1;
      tick();
      idle();
      chk("clr_op", opcode, 0); chk("clr_full", rs_full, 0);
      alu_valid = 1'b1; alu_rob_index = 6'd20; alu_res = 32'h5;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_none", opcode, 0);
      end

      // rdy_in stall
      issue(6'd9, 32'hA, 32'hB, 0, 0, 0, 0, 6'd11);
      tick();
      idle();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_op", opcode, 0);
      end
      rdy_in = 1'b1;
      tick();
      chk("stall_go", opcode, 9); chk("stall_v1", val1, 32'hA);

      // asynchronous reset between edges
      issue(6'd12, 0, 0, 1, 6'd33, 0, 0, 6'd13);
      tick();
      issue(6'd10, 32'hC, 32'hD, 0, 0, 0, 0, 6'd12);
      tick();
      idle();
      tick();
      chk("ar_pre", opcode, 10);
      #2 rst_in = 1'b1;
      #1;
      chk("ar_op", opcode, 0); chk("ar_v1", val1, 0);
      chk("ar_v2", val2, 0);   chk("ar_rob", rob_index, 0);
      chk("ar_pc", pc, 0);
      #2 rst_in = 1'b0;
      model_reset();
      alu_valid = 1'b1; alu_rob_index = 6'd33; alu_res = 32'h9;
      tick();
      idle();
      tick();
      chk("ar_flushed", opcode, 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rdy_in        = ($urandom % 8) != 0;
         clear         = ($urandom % 50) == 0;
         issue_valid   = $urandom % 2;
         issue_opcode  = 6'($urandom_range(1, 63));
         issue_val1    = $urandom; issue_val2 = $urandom;
         issue_dep1    = $urandom % 2; issue_dep2 = $urandom % 2;
         issue_tag1    = 6'($urandom % 8); issue_tag2 = 6'($urandom % 8);
         issue_imm     = $urandom; issue_pc = $urandom;
         issue_rob_index = 6'($urandom);
         alu_valid     = ($urandom % 3) == 0;
         alu_rob_index = 6'($urandom % 8); alu_res = $urandom;
         lsb_valid     = ($urandom % 3) == 0;
         lsb_rob_index = 6'($urandom % 8); lsb_res = $urandom;
         tick();
      end
      idle();
      rdy_in = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
